// File: rtl/dec_out_buf.sv
// Decoder output buffer: classifies decoder results, queues {class, data} in a
// circular FIFO and keeps saturating error statistics plus the last bad syndrome.

module dec_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + 1'b1;
  end
endmodule

module dec_out_buf #(
  parameter int DEPTH = 4,  // power of two, >= 2
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [30:0]      in_data,
  input  logic [9:0]       in_syn,
  input  logic             in_err,
  input  logic             in_sgl,
  input  logic             in_dbl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [30:0]      out_data,
  output logic [1:0]       out_status,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sgl_cnt,
  output logic [CNT_W-1:0] dbl_cnt,
  output logic [CNT_W-1:0] unc_cnt,
  output logic [9:0]       last_syn
);
  localparam int AW = $clog2(DEPTH);
  localparam int NCNT = 3;

  typedef struct packed {
    logic [1:0]  cls;
    logic [30:0] data;
  } ent_t;

  ent_t            mem [DEPTH];
  ent_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     occ;
  logic [1:0]      cls;
  logic            acc, pop;
  logic [NCNT-1:0] inc_vec;
  logic [NCNT-1:0][CNT_W-1:0] cnts;

  assign in_ready  = (occ != (AW+1)'(DEPTH));
  assign out_valid = (occ != '0);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flags only matter when ERR is set; sgl==dbl with ERR is uncorrectable.
  always_comb begin
    cls = 2'b00;
    if (in_err) begin
      case ({in_dbl, in_sgl})
        2'b01:   cls = 2'b01;
        2'b10:   cls = 2'b10;
        default: cls = 2'b11;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr] <= '{cls: cls, data: in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (acc) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({acc, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset, so the head is masked to zero whenever it is not valid.
  assign head       = mem[rd_ptr];
  assign out_data   = out_valid ? head.data : '0;
  assign out_status = out_valid ? head.cls  : '0;

  genvar i;
  generate
    for (i = 0; i < NCNT; i++) begin : g_cnt
      assign inc_vec[i] = acc && (cls == 2'(i+1));
      dec_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .inc  (inc_vec[i]),
        .cnt  (cnts[i])
      );
    end
  endgenerate

  assign sgl_cnt = cnts[0];
  assign dbl_cnt = cnts[1];
  assign unc_cnt = cnts[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      last_syn <= '0;
    else if (cnt_clr)                last_syn <= '0;
    else if (acc && (cls != 2'b00))  last_syn <= in_syn;
  end
endmodule

// File: tb/tb_dec_out_buf.sv
// Directed + random bench for dec_out_buf against a queue-based reference model.

module tb_dec_out_buf;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [30:0]      in_data;
  logic [9:0]       in_syn;
  logic             in_err, in_sgl, in_dbl;
  logic             out_valid, out_ready;
  logic [30:0]      out_data;
  logic [1:0]       out_status;
  logic             cnt_clr;
  logic [CNT_W-1:0] sgl_cnt, dbl_cnt, unc_cnt;
  logic [9:0]       last_syn;

  dec_out_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_syn(in_syn),
    .in_err(in_err), .in_sgl(in_sgl), .in_dbl(in_dbl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_status(out_status), .cnt_clr(cnt_clr),
    .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt), .unc_cnt(unc_cnt), .last_syn(last_syn)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  logic [32:0] q[$];
  int          m_cnt[3];
  logic [9:0]  m_syn;

  function automatic logic [1:0] classify(logic err, logic sgl, logic dbl);
    if (!err) return 2'b00;
    if (sgl && !dbl) return 2'b01;
    if (dbl && !sgl) return 2'b10;
    return 2'b11;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data",   32'(out_data),   32'(q[0][30:0]));
      chk("out_status", 32'(out_status), 32'(q[0][32:31]));
    end
    chk("sgl_cnt",  32'(sgl_cnt),  32'(m_cnt[0]));
    chk("dbl_cnt",  32'(dbl_cnt),  32'(m_cnt[1]));
    chk("unc_cnt",  32'(unc_cnt),  32'(m_cnt[2]));
    chk("last_syn", 32'(last_syn), 32'(m_syn));
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = '{0, 0, 0};
    m_syn = '0;
  endtask

  // One clock: drive, advance, update model, compare.
  task automatic step(logic v, logic [30:0] d, logic [9:0] s, logic e, logic sg,
                      logic db, logic ordy, logic clr);
    logic acc, pop;
    logic [1:0] c;
    in_valid = v; in_data = d; in_syn = s; in_err = e; in_sgl = sg; in_dbl = db;
    out_ready = ordy; cnt_clr = clr;
    acc = v && (q.size() < DEPTH);
    pop = ordy && (q.size() > 0);
    c = classify(e, sg, db);
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back({c, d});
    if (clr) begin
      m_cnt = '{0, 0, 0};
      m_syn = '0;
    end else if (acc && c != 2'b00) begin
      if (m_cnt[c-1] < CMAX) m_cnt[c-1]++;
      m_syn = s;
    end
    check_all();
  endtask

  task automatic idle(logic ordy);
    step(0, '0, '0, 0, 0, 0, ordy, 0);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = '0; in_syn = '0; in_err = 0;
    in_sgl = 0; in_dbl = 0; out_ready = 0; cnt_clr = 0;
    model_reset();
    #12;
    chk("rst_out_data",   32'(out_data),   0);
    chk("rst_out_status", 32'(out_status), 0);
    check_all();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // single clean word
    step(1, 31'h1, 10'h3FF, 0, 1, 1, 1, 0);
    idle(1);

    // three classes in sequence, held until all queued
    step(1, 31'h1111, 10'h2A5, 1, 1, 0, 0, 0);
    step(1, 31'h2222, 10'h0F0, 1, 0, 1, 0, 0);
    step(1, 31'h3333, 10'h155, 1, 1, 1, 0, 0);
    repeat (4) idle(1);

    // overfill with consumer stalled, then full + pop with input pending
    for (int i = 0; i < DEPTH + 1; i++)
      step(1, 31'(32'h100 + i), 10'(i + 1), 1, 0, 1, 0, 0);
    step(1, 31'h7777, 10'h3C3, 1, 1, 1, 1, 0);
    repeat (DEPTH + 1) idle(1);

    // saturation, then clear racing an increment
    for (int i = 0; i < 17; i++) step(1, 31'(i), 10'(i + 7), 1, 1, 0, 1, 0);
    step(1, 31'h55, 10'h2AA, 1, 1, 0, 1, 1);
    idle(1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 31'($urandom), 10'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);

    // mid-stream reset with words queued
    repeat (DEPTH) idle(1);
    for (int i = 0; i < 3; i++) step(1, 31'(32'hA0 + i), 10'h11, 1, 1, 0, 0, 0);
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("midrst_out_data", 32'(out_data), 0);
    check_all();
    @(negedge clk); rst_n = 1;
    step(1, 31'h0BEEF, 10'h22, 1, 0, 1, 0, 0);
    idle(1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
